ahb_lite_mem_slave: RTL and testbench
=====================================

// Module: ahb_lite_mem_slave
// PURPOSE
//  AHB-Lite slave with an internal word-addressed memory. It is the DUT that the AHB
//  driver and monitor stimulate and observe, and the scoreboard checks it.
//  Address/data phases are pipelined. Supports byte/halfword/word transfers with an
//  OKAY or two-cycle ERROR response. Wait-state insertion is optional.
// PARAMETERS
//  ADDR_WIDTH   32    HADDR width
//  DATA_WIDTH   32    HWDATA/HRDATA width (fixed at 32 for this block)
//  MEM_DEPTH    256   number of 32-bit words; valid byte range 0..MEM_DEPTH*4-1
//  WAIT_CYCLES  2     wait states per transfer (used only with AHB_SLV_WAIT_STATE_EN)
// PORTS
//  HCLK       in   1           clock; all logic on rising edge
//  HRESETn    in   1           reset, synchronous, active-low
//  HSEL       in   1           slave select
//  HADDR      in   ADDR_WIDTH  byte address (address phase)
//  HWRITE     in   1           1=write, 0=read
//  HSIZE      in   3           0=byte, 1=half, 2=word; >2 is an error
//  HBURST     in   3           burst type; accepted, no functional effect
//  HTRANS     in   2           0=IDLE 1=BUSY 2=NONSEQ 3=SEQ
//  HREADY     in   1           bus-level ready (previous transfer complete)
//  HWDATA     in   DATA_WIDTH  write data (data phase)
//  HRDATA     out  DATA_WIDTH  read data (data phase)
//  HREADYOUT  out  1           slave ready
//  HRESP      out  1           0=OKAY, 1=ERROR
// BEHAVIOUR
//  Reset: HRESETn==0 at a rising edge gives state=IDLE, HREADYOUT=1, HRESP=0,
//   HRDATA=0, and clears the wait counter and pending phase. Memory contents are kept.
//   A reset mid-transfer aborts it, and a pending write is NOT committed.
//  Accept: when HSEL & HREADY & HTRANS[1], register HADDR, HWRITE and HSIZE, then enter
//   the data phase the next cycle. IDLE/BUSY or !HSEL give an OKAY zero-wait response
//   with no access.
//  Error check at accept: HSIZE>2, misaligned (half: HADDR[0]!=0; word: HADDR[1:0]!=0),
//   or HADDR>=MEM_DEPTH*4. Any of these sends the FSM to ERR1, and there is no memory access.
//  FSM states: IDLE, DATA, WAIT, ERR1, ERR2.
//   IDLE -accept ok-> DATA (or WAIT if feature on)
//   IDLE -accept bad-> ERR1
//   WAIT: HREADYOUT=0 and counter decrements; go to DATA when the count reaches 1
//   DATA: HREADYOUT=1 and HRESP=0; the transfer completes at this edge. A new accept
//    goes back to DATA/WAIT/ERR1, otherwise to IDLE.
//   ERR1: HREADYOUT=0, HRESP=1, then go to ERR2
//   ERR2: HREADYOUT=1, HRESP=1; accept the next address phase as in DATA
//  Write: HWDATA is written at the completing edge of DATA, using byte lanes
//   from HSIZE and HADDR[1:0] (little-endian).
//  Read: HRDATA=mem[addr] on the registered address during DATA, with the full word
//   driven. HRDATA holds its last value outside DATA.
//  Write then read of the same address back-to-back: the read returns the new data,
//   because the write commits before the read's data phase.
// CONFIGURATION
//  `AHB_SLV_WAIT_STATE_EN defined: each accepted OKAY transfer spends WAIT_CYCLES
//   cycles in WAIT (HREADYOUT=0) before DATA. Errors do not add wait states.
//   WAIT_CYCLES=0 behaves as undefined.
//  Undefined: WAIT state unreachable; every OKAY transfer completes in 1 data cycle.
// STRUCTURE
//  Package ahb_slv_pkg: htrans_e, hsize_e, hresp_e, slv_state_e, and byte-lane
//   strobe function strb(hsize, addr[1:0]) returning 4 bits.
//  Sub-module ahb_slv_mem: MEM_DEPTH x 32 array with 4-bit byte write strobe,
//   async read port.
// TESTING
//  1 Reset: HRESETn=0 for 2 cycles -> HREADYOUT=1, HRESP=0, HRDATA=0.
//  2 Word write 0x10=0xDEADBEEF, then read 0x10 back-to-back -> HRDATA=0xDEADBEEF, OKAY.
//  3 Byte write 0xA5 to 0x13, then word read 0x10 -> 0xA5ADBEEF.
//  4 Read HADDR=MEM_DEPTH*4, then a misaligned half at 0x21 -> each gives
//    HREADYOUT 0 then 1 with HRESP=1 both cycles; memory unchanged.
//  5 INCR4 burst of SEQ writes at 0x40..0x4C, then reads -> data matches; with
//    AHB_SLV_WAIT_STATE_EN, WAIT_CYCLES=2 -> exactly 2 low HREADYOUT cycles per beat.
//  6 Assert HRESETn=0 during a write data phase to 0x50 -> back to IDLE; later read of
//    0x50 returns the old value.

Source files
------------

// File: rtl/ahb_slv_pkg.sv
// ahb_slv_pkg: shared types and the byte-lane strobe helper for the AHB-Lite
// memory slave (ahb_lite_mem_slave / ahb_slv_mem).
package ahb_slv_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'd0,
      HSIZE_HALF = 3'd1,
      HSIZE_WORD = 3'd2
   } hsize_e;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } hresp_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_DATA = 3'd1,
      ST_WAIT = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } slv_state_e;

   // Little-endian byte-lane enables for a transfer of size hsize at byte offset addr.
   function automatic logic [3:0] strb(input logic [2:0] hsize, input logic [1:0] addr);
      logic [3:0] s;
      case (hsize)
         3'd0:    s = 4'b0001 << addr;
         3'd1:    s = addr[1] ? 4'b1100 : 4'b0011;
         3'd2:    s = 4'b1111;
         default: s = 4'b0000;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/ahb_slv_mem.sv
// ahb_slv_mem: MEM_DEPTH x 32-bit word memory with per-byte write strobes and an
// asynchronous read port. Contents are never reset.
module ahb_slv_mem #(
   parameter int MEM_DEPTH = 256,
   parameter int IDX_W     = 8
) (
   input  logic             clk,
   input  logic             we,
   input  logic [3:0]       wstrb,
   input  logic [IDX_W-1:0] waddr,
   input  logic [31:0]      wdata,
   input  logic [IDX_W-1:0] raddr,
   output logic [31:0]      rdata
);

   logic [31:0] mem_r [MEM_DEPTH];

   // Commit the enabled byte lanes of the write word.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
               mem_r[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// ahb_lite_mem_slave: AHB-Lite slave in front of a word-addressed memory.
// Pipelined address/data phases, byte/half/word transfers, two-cycle ERROR
// response for bad size, misalignment or out-of-range address.
// Optional feature: define AHB_SLV_WAIT_STATE_EN to insert WAIT_CYCLES wait
// states before every OKAY data phase (WAIT_CYCLES=0 behaves as undefined).
module ahb_lite_mem_slave
   import ahb_slv_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [1:0]            HTRANS,
   input  logic                  HREADY,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP
);

   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * 4);
`ifdef AHB_SLV_WAIT_STATE_EN
   localparam bit WAIT_EN = (WAIT_CYCLES > 0);
`else
   localparam bit WAIT_EN = 1'b0;
`endif

   slv_state_e       state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [IDX_W-1:0] idx_r;
   logic [1:0]       lane_r;
   logic             write_r;
   logic [2:0]       size_r;
   logic [31:0]      hrdata_r;
   logic             hreadyout_r;
   hresp_e           hresp_r;

   logic             acc_s, err_s, cap_s, load_rd_s;
   logic             mem_we_s;
   logic [3:0]       mem_strb_s;
   logic [IDX_W-1:0] rd_idx_s;
   logic [31:0]      rd_word_s, fwd_word_s;
   logic             unused_s;

   assign unused_s = ^{HBURST, HTRANS[0]};

   assign acc_s = HSEL & HREADY & HTRANS[1];
   assign err_s = (HSIZE > 3'd2)
                | ((HSIZE == 3'd1) & HADDR[0])
                | ((HSIZE == 3'd2) & (|HADDR[1:0]))
                | ({1'b0, HADDR} >= MEM_BYTES);

   // A write in DATA commits at its completing edge unless reset aborts it.
   assign mem_we_s   = (state_r == ST_DATA) & write_r & HRESETn;
   assign mem_strb_s = strb(size_r, lane_r);
   assign rd_idx_s   = (state_r == ST_WAIT) ? idx_r : HADDR[IDX_W+1:2];

   ahb_slv_mem #(
      .MEM_DEPTH (MEM_DEPTH),
      .IDX_W     (IDX_W)
   ) u_mem (
      .clk   (HCLK),
      .we    (mem_we_s),
      .wstrb (mem_strb_s),
      .waddr (idx_r),
      .wdata (HWDATA),
      .raddr (rd_idx_s),
      .rdata (rd_word_s)
   );

   // Merge a same-edge write into the read word so a back-to-back read sees new data.
   always_comb begin
      fwd_word_s = rd_word_s;
      for (int b = 0; b < 4; b++) begin
         fwd_word_s[8*b +: 8] = (mem_we_s && (idx_r == rd_idx_s) && mem_strb_s[b])
                              ? HWDATA[8*b +: 8] : rd_word_s[8*b +: 8];
      end
   end

   // Next-state decode: accept new address phases, run wait count and error sequence.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      cap_s     = 1'b0;
      load_rd_s = 1'b0;
      case (state_r)
         ST_WAIT: begin
            if (cnt_r <= CNT_W'(1)) begin
               state_s   = ST_DATA;
               load_rd_s = ~write_r;
            end else begin
               cnt_s = cnt_r - CNT_W'(1);
            end
         end
         ST_ERR1: state_s = ST_ERR2;
         ST_IDLE, ST_DATA, ST_ERR2: begin
            if (acc_s) begin
               cap_s = 1'b1;
               if (err_s) begin
                  state_s = ST_ERR1;
               end else if (WAIT_EN) begin
                  state_s = ST_WAIT;
                  cnt_s   = CNT_W'(WAIT_CYCLES);
               end else begin
                  state_s   = ST_DATA;
                  load_rd_s = ~HWRITE;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State, captured address phase and registered bus outputs.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_r     <= ST_IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         idx_r       <= {IDX_W{1'b0}};
         lane_r      <= 2'b00;
         write_r     <= 1'b0;
         size_r      <= 3'd0;
         hrdata_r    <= 32'h0000_0000;
         hreadyout_r <= 1'b1;
         hresp_r     <= HRESP_OKAY;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         if (cap_s) begin
            idx_r   <= HADDR[IDX_W+1:2];
            lane_r  <= HADDR[1:0];
            write_r <= HWRITE;
            size_r  <= HSIZE;
         end
         if (load_rd_s) begin
            hrdata_r <= fwd_word_s;
         end
         hreadyout_r <= !((state_s == ST_WAIT) || (state_s == ST_ERR1));
         hresp_r     <= ((state_s == ST_ERR1) || (state_s == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      end
   end

   assign HRDATA    = hrdata_r;
   assign HREADYOUT = hreadyout_r;
   assign HRESP     = hresp_r;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Self-checking bench for ahb_lite_mem_slave: directed scenarios plus random
// transfers checked against a byte-addressed reference memory.
module tb_ahb_lite_mem_slave;

   localparam int MEM_DEPTH   = 256;
   localparam int WAIT_CYCLES = 2;
`ifdef AHB_SLV_WAIT_STATE_EN
   localparam int EXP_WAITS = WAIT_CYCLES;
`else
   localparam int EXP_WAITS = 0;
`endif

   logic        HCLK = 1'b0;
   logic        HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [2:0]  HSIZE, HBURST;
   logic [1:0]  HTRANS;

   always #5 HCLK = ~HCLK;
   assign HREADY = HREADYOUT;

   ahb_lite_mem_slave #(
      .ADDR_WIDTH (32), .DATA_WIDTH (32), .MEM_DEPTH (MEM_DEPTH), .WAIT_CYCLES (WAIT_CYCLES)
   ) dut (
      .HCLK (HCLK), .HRESETn (HRESETn), .HSEL (HSEL), .HADDR (HADDR), .HWRITE (HWRITE),
      .HSIZE (HSIZE), .HBURST (HBURST), .HTRANS (HTRANS), .HREADY (HREADY),
      .HWDATA (HWDATA), .HRDATA (HRDATA), .HREADYOUT (HREADYOUT), .HRESP (HRESP)
   );

   logic [31:0] mem_m [MEM_DEPTH];
   logic [31:0] last_rdata;
   int          n_tests = 0;
   int          n_fail  = 0;

   // pending data phase (the transfer whose address phase was accepted last)
   bit          p_valid, p_write, p_err;
   logic [31:0] p_addr, p_wdata;
   logic [2:0]  p_size;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic bit is_err(input logic [2:0] size, input logic [31:0] addr);
      if (size > 3'd2) return 1'b1;
      if (addr >= 32'(MEM_DEPTH * 4)) return 1'b1;
      return (addr % (32'd1 << size)) != 32'd0;
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
      for (int b = 0; b < (1 << size); b++) begin
         int unsigned a;
         a = addr + b;
         mem_m[a / 4][8 * (a % 4) +: 8] = wdata[8 * (a % 4) +: 8];
      end
   endtask

   // One bus step: present a new address phase, finish the pending data phase.
   task automatic step(input bit sel, input logic [1:0] trans, input logic [31:0] addr,
                       input bit wr, input logic [2:0] size, input logic [31:0] wdata);
      int lows;
      bit done;
      HSEL = sel; HTRANS = trans; HADDR = addr; HWRITE = wr; HSIZE = size; HWDATA = p_wdata;
      lows = 0;
      done = 1'b0;
      while (!done) begin
         if (HREADYOUT === 1'b1) begin
            done = 1'b1;
         end else begin
            lows++;
            if (p_valid && p_err && lows == 1) check("err1_hresp", {31'd0, HRESP}, 32'd1);
            check("wait_hold_rdata", HRDATA, last_rdata);
            if (lows > 16) begin
               check("wait_bound", 32'(lows), 32'd16);
               done = 1'b1;
            end else begin
               @(posedge HCLK);
               @(negedge HCLK);
            end
         end
      end
      if (p_valid) begin
         check("low_cycles", 32'(lows), p_err ? 32'd1 : 32'(EXP_WAITS));
         check("hresp", {31'd0, HRESP}, {31'd0, p_err});
         if (!p_err && !p_write) begin
            check("rdata", HRDATA, mem_m[p_addr / 4]);
            last_rdata = mem_m[p_addr / 4];
         end else begin
            check("hold_rdata", HRDATA, last_rdata);
         end
         if (!p_err && p_write) model_write(p_addr, p_size, p_wdata);
      end else begin
         check("idle_low_cycles", 32'(lows), 32'd0);
         check("idle_hresp", {31'd0, HRESP}, 32'd0);
         check("idle_hold_rdata", HRDATA, last_rdata);
      end
      @(posedge HCLK);
      @(negedge HCLK);
      p_valid = sel && trans[1];
      p_write = wr;
      p_addr  = addr;
      p_size  = size;
      p_wdata = wdata;
      p_err   = is_err(size, addr);
   endtask

   task automatic idle();
      step(1'b0, 2'd0, 32'd0, 1'b0, 3'd0, 32'd0);
   endtask

   initial begin
      HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'd0; HADDR = 32'd0; HWRITE = 1'b0;
      HSIZE = 3'd0; HBURST = 3'd0; HWDATA = 32'd0;
      p_valid = 1'b0; p_write = 1'b0; p_err = 1'b0; p_addr = 32'd0; p_wdata = 32'd0; p_size = 3'd0;
      last_rdata = 32'd0;

      // 1: reset for two cycles
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      check("reset_hreadyout", {31'd0, HREADYOUT}, 32'd1);
      check("reset_hresp", {31'd0, HRESP}, 32'd0);
      check("reset_hrdata", HRDATA, 32'd0);
      HRESETn = 1'b1;

      // preload the whole memory with random words so every read is defined
      for (int i = 0; i < MEM_DEPTH; i++) step(1'b1, 2'd2, 32'(i * 4), 1'b1, 3'd2, $urandom);
      idle();

      // 2: word write then back-to-back read
      step(1'b1, 2'd2, 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF);
      step(1'b1, 2'd2, 32'h10, 1'b0, 3'd2, 32'd0);
      idle();
      check("t2_rdata", HRDATA, 32'hDEAD_BEEF);

      // 3: byte write to lane 3, then word read
      step(1'b1, 2'd2, 32'h13, 1'b1, 3'd0, 32'hA500_0000);
      step(1'b1, 2'd2, 32'h10, 1'b0, 3'd2, 32'd0);
      idle();
      check("t3_rdata", HRDATA, 32'hA5AD_BEEF);

      // 4: out-of-range read, misaligned half write, then confirm memory intact
      step(1'b1, 2'd2, 32'(MEM_DEPTH * 4), 1'b0, 3'd2, 32'd0);
      step(1'b1, 2'd2, 32'h21, 1'b1, 3'd1, 32'h1234_1234);
      step(1'b1, 2'd2, 32'h20, 1'b0, 3'd2, 32'd0);
      idle();

      // 5: INCR4 burst of writes, then burst of reads
      HBURST = 3'b011;
      for (int i = 0; i < 4; i++)
         step(1'b1, (i == 0) ? 2'd2 : 2'd3, 32'(32'h40 + i * 4), 1'b1, 3'd2, 32'hC0DE_0000 + 32'(i));
      for (int i = 0; i < 4; i++)
         step(1'b1, (i == 0) ? 2'd2 : 2'd3, 32'(32'h40 + i * 4), 1'b0, 3'd2, 32'd0);
      idle();
      HBURST = 3'b000;
      check("t5_last_beat", HRDATA, 32'hC0DE_0003);

      // 6: reset during a write data phase; the write must not commit
      step(1'b1, 2'd2, 32'h50, 1'b1, 3'd2, 32'h1111_2222);
      idle();
      step(1'b1, 2'd2, 32'h50, 1'b1, 3'd2, 32'h9999_9999);
      HWDATA = 32'h9999_9999; HSEL = 1'b0; HTRANS = 2'd0; HRESETn = 1'b0;
      @(posedge HCLK);
      @(negedge HCLK);
      check("t6_reset_hreadyout", {31'd0, HREADYOUT}, 32'd1);
      check("t6_reset_hresp", {31'd0, HRESP}, 32'd0);
      check("t6_reset_hrdata", HRDATA, 32'd0);
      HRESETn = 1'b1;
      p_valid = 1'b0; p_wdata = 32'd0; last_rdata = 32'd0;
      step(1'b1, 2'd2, 32'h50, 1'b0, 3'd2, 32'd0);
      idle();
      check("t6_old_value", HRDATA, 32'h1111_2222);

      // random traffic against the reference memory
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         logic [2:0]  sz;
         a  = ($urandom_range(0, 15) == 0) ? 32'(MEM_DEPTH * 4) + 32'($urandom_range(0, 63))
                                           : 32'($urandom_range(0, MEM_DEPTH * 4 - 1));
         sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         if (sz != 3'd0 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
         HBURST = 3'($urandom_range(0, 7));
         step($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), a,
              1'($urandom_range(0, 1)), sz, $urandom);
      end
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
